imem_fetch_unit: RTL and testbench

Parametrised, registered instruction memory for the ARM-subset pipeline, replacing the combinational case-ROM fetch path. It accepts fetch requests on a byte address and returns instruction words after a configurable number of wait states. It exposes a loader write port so test programs can be written at run time instead of being hard-coded. It sits between the IF-stage PC register and the IF/ID pipeline register; `ready` doubles as the IF-stage stall release.

---
 rtl/imem_fetch_unit.sv | 119 +++++++++++
 tb/tb_imem_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Registered instruction memory with wait-state fetch FSM and a run-time loader write port.
// Optional build macro IMEM_ALIGN_CHECK_EN: misaligned fetches fault and misaligned loader writes are dropped.
module imem_fetch_unit #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 256,
    parameter int                ADDR_W      = 32,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0,
    parameter string             INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic [DATA_W-1:0] inst,
    output logic              fault,
    output logic              busy,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ack
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_inst;
    logic              r_fault;
    logic              r_busy;
    logic [DATA_W-1:0] r_pend_inst;
    logic              r_pend_fault;
    logic              r_load_ack;

    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_load_idx;
    logic              w_fetch_fault;
    logic              w_load_ok;
    logic              w_accept;
    logic [DATA_W-1:0] w_word;

    assign w_idx      = addr[IDX_W+1:2];
    assign w_load_idx = load_addr[IDX_W+1:2];

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_fetch_fault = (|addr[ADDR_W-1:IDX_W+2]) | (|addr[1:0]);
    assign w_load_ok     = ~(|load_addr[ADDR_W-1:IDX_W+2]) & ~(|load_addr[1:0]);
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{addr[1:0], load_addr[1:0]};
    assign w_fetch_fault = |addr[ADDR_W-1:IDX_W+2];
    assign w_load_ok     = ~(|load_addr[ADDR_W-1:IDX_W+2]);
`endif

    // RESP doubles as an accept slot so back-to-back fetches need no idle gap.
    assign w_accept = req && (r_state == S_IDLE || r_state == S_RESP);
    assign w_word   = w_fetch_fault ? NOP_WORD : r_mem[w_idx];

    // Array write has no reset so contents survive rst; the fetch read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_we && w_load_ok) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_inst       <= NOP_WORD;
            r_fault      <= 1'b0;
            r_busy       <= 1'b0;
            r_pend_inst  <= NOP_WORD;
            r_pend_fault <= 1'b0;
            r_load_ack   <= 1'b0;
        end else begin
            r_load_ack <= load_we;
            r_ready    <= 1'b0;
            if (w_accept) begin
                r_pend_inst  <= w_word;
                r_pend_fault <= w_fetch_fault;
                if (WAIT_STATES == 0) begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_inst  <= w_word;
                    r_fault <= w_fetch_fault;
                end else begin
                    r_state <= S_WAIT;
                    r_cnt   <= CNT_W'(WAIT_STATES);
                    r_busy  <= 1'b1;
                end
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    r_state <= S_RESP;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_inst  <= r_pend_inst;
                    r_fault <= r_pend_fault;
                end
            end else if (r_state == S_RESP) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign ready    = r_ready;
    assign inst     = r_inst;
    assign fault    = r_fault;
    assign busy     = r_busy;
    assign load_ack = r_load_ack;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: three instances with 0, 3 and 2 wait states sharing the loader and reset.
module tb_imem_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_we = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic        req0 = 1'b0, req3 = 1'b0, req2 = 1'b0;
    logic [31:0] addr0 = '0, addr3 = '0, addr2 = '0;
    logic        ready0, ready3, ready2;
    logic [31:0] inst0, inst3, inst2;
    logic        fault0, fault3, fault2;
    logic        busy0, busy3, busy2;
    logic        ack0, ack3, ack2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_fetch_unit #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .addr(addr0), .ready(ready0), .inst(inst0),
        .fault(fault0), .busy(busy0), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_ack(ack0));
    imem_fetch_unit #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .addr(addr3), .ready(ready3), .inst(inst3),
        .fault(fault3), .busy(busy3), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_ack(ack3));
    imem_fetch_unit #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .addr(addr2), .ready(ready2), .inst(inst2),
        .fault(fault2), .busy(busy2), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .load_ack(ack2));

`ifdef IMEM_ALIGN_CHECK_EN
    localparam logic [31:0] EXP6_INST  = 32'h0000_0000;
    localparam logic        EXP6_FAULT = 1'b1;
    localparam logic [31:0] EXP10_INST = 32'hAAAA_0000;
`else
    localparam logic [31:0] EXP6_INST  = 32'hE3A0_1015;
    localparam logic        EXP6_FAULT = 1'b0;
    localparam logic [31:0] EXP10_INST = 32'h5555_5555;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        fault;
    } vec_t;
    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        chk($sformatf("load_ack after write %h", a), {31'b0, ack0}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 32'hE3A0_0A01, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'hE3A0_1015, 1'b0};
        vecs[2] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0006, EXP6_INST,     EXP6_FAULT};
        vecs[4] = '{32'h0000_0010, EXP10_INST,    1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_000C, 32'h3333_4444, 1'b0};
        vecs[7] = '{32'h0000_0008, 32'h1111_2222, 1'b0};

        // reset state
        tick();
        tick();
        chk("reset ready", {31'b0, ready0}, 32'd0);
        chk("reset inst", inst0, 32'd0);
        chk("reset fault", {31'b0, fault0}, 32'd0);
        chk("reset busy", {31'b0, busy3}, 32'd0);
        chk("reset load_ack", {31'b0, ack0}, 32'd0);
        rst = 1'b1;
        tick();

        // program load, including a dropped out-of-range write and a misaligned one
        wr(32'h0000_0000, 32'hE3A0_0A01);
        wr(32'h0000_0004, 32'hE3A0_1015);
        wr(32'h0000_0008, 32'h1111_2222);
        wr(32'h0000_000C, 32'h3333_4444);
        wr(32'h0000_0400, 32'hBADB_AD00);
        wr(32'h0000_0010, 32'hAAAA_0000);
        wr(32'h0000_0011, 32'h5555_5555);
        load_we = 1'b0;
        tick();
        chk("load_ack idle", {31'b0, ack0}, 32'd0);

        // zero-wait back-to-back table
        for (int i = 0; i < 8; i++) begin
            req0  = 1'b1;
            addr0 = vecs[i].addr;
            tick();
            chk($sformatf("w0 ready %h", vecs[i].addr), {31'b0, ready0}, 32'd1);
            chk($sformatf("w0 inst %h", vecs[i].addr), inst0, vecs[i].inst);
            chk($sformatf("w0 fault %h", vecs[i].addr), {31'b0, fault0}, {31'b0, vecs[i].fault});
        end
        req0 = 1'b0;
        tick();
        chk("w0 ready drops", {31'b0, ready0}, 32'd0);
        chk("w0 inst holds", inst0, 32'h1111_2222);

        // same-cycle write and fetch: old word, then new word
        req0 = 1'b1; addr0 = 32'h0000_000C;
        load_we = 1'b1; load_addr = 32'h0000_000C; load_data = 32'hDEAD_BEEF;
        tick();
        chk("rbw old word", inst0, 32'h3333_4444);
        chk("rbw load_ack", {31'b0, ack0}, 32'd1);
        load_we = 1'b0;
        tick();
        chk("rbw new word", inst0, 32'hDEAD_BEEF);
        chk("rbw ack single", {31'b0, ack0}, 32'd0);
        req0 = 1'b0;
        tick();

        // three wait states with a request raised mid-wait
        req3 = 1'b1; addr3 = 32'h0000_0008;
        tick();
        addr3 = 32'h0000_0000;
        chk("w3 busy c1", {31'b0, busy3}, 32'd1);
        chk("w3 ready c1", {31'b0, ready3}, 32'd0);
        tick();
        chk("w3 busy c2", {31'b0, busy3}, 32'd1);
        chk("w3 ready c2", {31'b0, ready3}, 32'd0);
        tick();
        chk("w3 busy c3", {31'b0, busy3}, 32'd1);
        chk("w3 ready c3", {31'b0, ready3}, 32'd0);
        req3 = 1'b0;
        tick();
        chk("w3 ready c4", {31'b0, ready3}, 32'd1);
        chk("w3 busy c4", {31'b0, busy3}, 32'd0);
        chk("w3 inst c4", inst3, 32'h1111_2222);
        chk("w3 fault c4", {31'b0, fault3}, 32'd0);
        tick();
        chk("w3 ready c5", {31'b0, ready3}, 32'd0);
        tick();
        chk("w3 mid-wait req ignored ready", {31'b0, ready3}, 32'd0);
        chk("w3 mid-wait req ignored busy", {31'b0, busy3}, 32'd0);

        // request held through RESP is accepted again
        req3 = 1'b1; addr3 = 32'h0000_0004;
        tick();
        tick();
        tick();
        tick();
        chk("w3 b2b first ready", {31'b0, ready3}, 32'd1);
        chk("w3 b2b first inst", inst3, 32'hE3A0_1015);
        addr3 = 32'h0000_0000;
        tick();
        chk("w3 b2b accepted busy", {31'b0, busy3}, 32'd1);
        chk("w3 b2b accepted ready", {31'b0, ready3}, 32'd0);
        req3 = 1'b0;
        tick();
        tick();
        tick();
        chk("w3 b2b second ready", {31'b0, ready3}, 32'd1);
        chk("w3 b2b second inst", inst3, 32'hE3A0_0A01);
        tick();

        // two wait states: normal fetch, then reset during WAIT
        req2 = 1'b1; addr2 = 32'h0000_0000;
        tick();
        req2 = 1'b0;
        tick();
        tick();
        chk("w2 ready", {31'b0, ready2}, 32'd1);
        chk("w2 inst", inst2, 32'hE3A0_0A01);
        tick();
        req2 = 1'b1; addr2 = 32'h0000_0004;
        tick();
        req2 = 1'b0;
        chk("w2 busy before rst", {31'b0, busy2}, 32'd1);
        rst = 1'b0;
        #1;
        chk("w2 rst ready", {31'b0, ready2}, 32'd0);
        chk("w2 rst busy", {31'b0, busy2}, 32'd0);
        chk("w2 rst inst", inst2, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("w2 no resp a", {31'b0, ready2}, 32'd0);
        tick();
        tick();
        chk("w2 no resp b", {31'b0, ready2 | busy2}, 32'd0);
        req2 = 1'b1; addr2 = 32'h0000_0004;
        tick();
        req2 = 1'b0;
        tick();
        tick();
        chk("w2 post-rst ready", {31'b0, ready2}, 32'd1);
        chk("w2 post-rst inst", inst2, 32'hE3A0_1015);
        chk("w2 post-rst fault", {31'b0, fault2}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
